// File: rtl/data_demux_pkg.sv
// Shared constants for the inbound data-bus demux: destination indices,
// bus direction encoding and the demux FSM state type.
package data_demux_pkg;

  localparam logic [2:0] DST_A    = 3'd0;
  localparam logic [2:0] DST_X    = 3'd1;
  localparam logic [2:0] DST_Y    = 3'd2;
  localparam logic [2:0] DST_P    = 3'd3;
  localparam logic [2:0] DST_DL   = 3'd4;
  localparam logic [2:0] DST_PCL  = 3'd5;
  localparam logic [2:0] DST_PCH  = 3'd6;
  localparam logic [2:0] DST_NONE = 3'd7;

  localparam int NUM_DST = 7;

  // Same polarity as the outbound source-select mux.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

endpackage

// File: rtl/data_demux_wait_counter.sv
// Loadable down-counter used to insert fixed memory wait states.
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_demux.sv
// Samples the external data bus on CPU reads and strobes the byte into one
// of seven destination latches, honouring wait states and mem_ready.
module data_demux
  import data_demux_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int WCNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           bus_data,
  input  logic                 mem_ready,
  input  logic                 req,
  input  logic                 rw_in,
  input  logic [2:0]           dest_sel,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_DST-1:0]   load_en,
  output logic [7:0]           load_data,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic        rw_q, rw_d;
  logic [7:0]  data_q, data_d;
  logic        overrun_q, overrun_d;

  logic              cnt_load, cnt_dec, cnt_zero;
  logic [WCNT_W-1:0] cnt;

  wait_counter #(.W(WCNT_W)) u_wait (
    .clk        (clk),
    .rst        (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (WCNT_W'(WAIT_CYCLES)),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rw_d     = rw_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    done     = 1'b0;
    load_en  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          sel_d    = dest_sel;
          rw_d     = rw_in;
          cnt_load = 1'b1;
          state_d  = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt == WCNT_W'(1) || cnt_zero) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (mem_ready) begin
          if (rw_q == RW_READ) begin
            data_d  = bus_data;
            state_d = ST_LOAD;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        done    = 1'b1;
        // DST_NONE discards: the byte is captured but nobody is strobed.
        if (sel_q != DST_NONE) load_en[sel_q] = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A stray request always wins over a same-cycle clear.
  assign overrun_d = (req && busy) || (overrun_q && !overrun_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= DST_NONE;
      rw_q      <= RW_WRITE;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rw_q      <= rw_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign load_data = data_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_data_demux.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has three.
module tb_data_demux;

  typedef struct {
    int         cyc;
    logic [6:0] en;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst       [2];
  logic [7:0] bdata     [2];
  logic       mready    [2];
  logic       req       [2];
  logic       rw        [2];
  logic [2:0] dsel      [2];
  logic       ovclr     [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic [6:0] load_en_o [2];
  logic [7:0] ldata_o   [2];
  logic       overrun_o [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  data_demux #(.WAIT_CYCLES(0), .WCNT_W(4)) u_dut0 (
    .clk(clk), .reset(rst[0]), .bus_data(bdata[0]), .mem_ready(mready[0]),
    .req(req[0]), .rw_in(rw[0]), .dest_sel(dsel[0]), .busy(busy_o[0]),
    .done(done_o[0]), .load_en(load_en_o[0]), .load_data(ldata_o[0]),
    .overrun(overrun_o[0]), .overrun_clr(ovclr[0])
  );

  data_demux #(.WAIT_CYCLES(3), .WCNT_W(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .bus_data(bdata[1]), .mem_ready(mready[1]),
    .req(req[1]), .rw_in(rw[1]), .dest_sel(dsel[1]), .busy(busy_o[1]),
    .done(done_o[1]), .load_en(load_en_o[1]), .load_data(ldata_o[1]),
    .overrun(overrun_o[1]), .overrun_clr(ovclr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [6:0] en, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.en = en; e.data = d;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_evt(input int k);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_evt%0d: done=%0b load_en=%b with nothing expected (cycle %0d)",
               k, done_o[k], load_en_o[k], cyc);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("evt%0d_cycle", k), cyc, e.cyc);
      chk($sformatf("evt%0d_load_en", k), int'(load_en_o[k]), int'(e.en));
      chk($sformatf("evt%0d_load_data", k), int'(ldata_o[k]), int'(e.data));
      chk($sformatf("evt%0d_done", k), int'(done_o[k]), 1);
    end
  endtask

  // Monitor: any output activity must match the head of that instance's queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (done_o[k] || load_en_o[k] != 7'd0) check_evt(k);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    int g = 0;
    while (cyc < t && g < 500) begin
      step();
      g++;
    end
  endtask

  task automatic issue(input int k, input logic r, input logic [2:0] d);
    req[k] = 1'b1; rw[k] = r; dsel[k] = d;
    step();
    req[k] = 1'b0; rw[k] = ~r; dsel[k] = 3'd5;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; bdata[k] = 8'h00; mready[k] = 1'b0; req[k] = 1'b0;
      rw[k] = 1'b0; dsel[k] = 3'd0; ovclr[k] = 1'b0;
    end
    step(); step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_busy", k), int'(busy_o[k]), 0);
      chk($sformatf("rst%0d_done", k), int'(done_o[k]), 0);
      chk($sformatf("rst%0d_load_en", k), int'(load_en_o[k]), 0);
      chk($sformatf("rst%0d_overrun", k), int'(overrun_o[k]), 0);
      chk($sformatf("rst%0d_load_data", k), int'(ldata_o[k]), 0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    step(); step();

    // Read, no wait states: strobe two cycles after req.
    mready[0] = 1'b1; bdata[0] = 8'hA5; n = cyc;
    push(0, n + 2, 7'b0000100, 8'hA5);
    issue(0, 1'b1, 3'd2);
    chk("busy_after_req", int'(busy_o[0]), 1);
    wait_until(n + 4);

    // Write: done in the ACK cycle, captured byte untouched.
    bdata[0] = 8'h5E; n = cyc;
    push(0, n + 1, 7'b0000000, 8'hA5);
    issue(0, 1'b0, 3'd0);
    wait_until(n + 4);

    // Discard destination still captures the byte.
    bdata[0] = 8'hFF; n = cyc;
    push(0, n + 2, 7'b0000000, 8'hFF);
    issue(0, 1'b1, 3'd7);
    wait_until(n + 4);

    // Reset landing in LOAD kills the strobe and the done pulse.
    bdata[0] = 8'h77; n = cyc;
    issue(0, 1'b1, 3'd1);
    wait_until(n + 2);
    rst[0] = 1'b1;
    #1;
    chk("midload_load_en", int'(load_en_o[0]), 0);
    chk("midload_busy", int'(busy_o[0]), 0);
    chk("midload_load_data", int'(ldata_o[0]), 0);
    step(); step();
    rst[0] = 1'b0;
    step(); step(); step();

    // Three wait states plus two ACK stalls; only the ready-edge byte counts.
    mready[1] = 1'b0; bdata[1] = 8'h11; n = cyc;
    push(1, n + 7, 7'b1000000, 8'h3C);
    issue(1, 1'b1, 3'd6);
    wait_until(n + 6);
    mready[1] = 1'b1; bdata[1] = 8'h3C;
    step();
    mready[1] = 1'b0; bdata[1] = 8'h22;
    wait_until(n + 10);

    // Stray requests during WAIT: set beats clear, lone clear wins afterwards.
    mready[1] = 1'b1; bdata[1] = 8'h5A; n = cyc;
    push(1, n + 5, 7'b0000010, 8'h5A);
    issue(1, 1'b1, 3'd1);
    req[1] = 1'b1; rw[1] = 1'b0; dsel[1] = 3'd3;
    step();
    chk("overrun_set", int'(overrun_o[1]), 1);
    ovclr[1] = 1'b1;
    step();
    req[1] = 1'b0; ovclr[1] = 1'b0;
    chk("overrun_set_wins", int'(overrun_o[1]), 1);
    ovclr[1] = 1'b1;
    step();
    ovclr[1] = 1'b0;
    chk("overrun_cleared", int'(overrun_o[1]), 0);
    wait_until(n + 8);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
